// File: rtl/tlc_pkg.sv
// Shared types for the multi-phase traffic-light controller.
//   state_e       : controller state (all-red clearance, green, yellow)
//   lamp_e        : which lamp the owning phase shows
//   lamp_of_state : maps a controller state to the owning phase's lamp
package tlc_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        LAMP_RED = 2'd0,
        LAMP_GRN = 2'd1,
        LAMP_YLW = 2'd2
    } lamp_e;

    // Lamp lit on the owning phase for a given state; every other phase stays red.
    function automatic lamp_e lamp_of_state(input state_e s);
        lamp_e l;
        case (s)
            ST_GREEN:  l = LAMP_GRN;
            ST_YELLOW: l = LAMP_YLW;
            default:   l = LAMP_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tlc_multi_phase_if.sv
// Controller <-> intersection bundle.
//   test  : 1 = one timing tick per clock (prescaler bypassed)
//   req   : per-phase vehicle sensors (bit 0, the main road, is ignored)
//   grn/ylw/red : lamp drives, one bit per phase
//   phase : phase owning green/yellow, or the last owner during all-red
//   tick  : one-cycle strobe per timing tick
interface tlc_multi_phase_if #(
    parameter int unsigned N_PHASE = 4
) ();
    localparam int unsigned PH_W = $clog2(N_PHASE);

    logic               test;
    logic [N_PHASE-1:0] req;
    logic [N_PHASE-1:0] grn;
    logic [N_PHASE-1:0] ylw;
    logic [N_PHASE-1:0] red;
    logic [PH_W-1:0]    phase;
    logic               tick;

    modport master (
        input  test, req,
        output grn, ylw, red, phase, tick
    );

    modport slave (
        output test, req,
        input  grn, ylw, red, phase, tick
    );
endinterface

// File: rtl/tlc_prescaler.sv
// Timing-tick generator.
//   clk, rst : clock, asynchronous active-high reset
//   test     : raw fast-mode request (synchronised here)
//   tick     : registered strobe; every cycle in fast mode, otherwise once per PRESCALE cycles
module tlc_prescaler #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic test,
    output logic tick
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic          test_q;
    logic [PW-1:0] cnt;
    logic [PW-1:0] cnt_n;
    logic          tick_n;

    // tick is kept equal to (test_q | cnt == PRESCALE-1) by computing it from next-cycle values.
    // Holding cnt at 0 while in fast mode makes a return to normal mode restart the count.
    always_comb begin
        cnt_n  = (test_q || tick) ? '0 : cnt + PW'(1);
        tick_n = test || (cnt_n == PW'(PRESCALE - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            test_q <= 1'b0;
            cnt    <= '0;
            tick   <= 1'b0;
        end else begin
            test_q <= test;
            cnt    <= cnt_n;
            tick   <= tick_n;
        end
    end
endmodule

// File: rtl/tlc_multi_phase.sv
// Multi-phase traffic-light controller: latched per-phase demand, round-robin
// service with phase 0 (main road) as the default green, prescaled interval timing.
//   CK  : clock, rising edge
//   CLR : asynchronous active-high reset (all lamps red immediately)
//   io  : sensors/test mode in, registered lamp drives, phase and tick out
module tlc_multi_phase
    import tlc_pkg::*;
#(
    parameter int unsigned N_PHASE     = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned PRESCALE    = 16,
    parameter int unsigned GREEN_MIN   = 4,
    parameter int unsigned GREEN_MAX   = 12,
    parameter int unsigned YLW_TIME    = 2,
    parameter int unsigned ALLRED_TIME = 1
) (
    input logic              CK,
    input logic              CLR,
    tlc_multi_phase_if.master io
);
    localparam int unsigned PH_W = $clog2(N_PHASE);
    localparam int unsigned TW   = CNT_W + 1;

    state_e             state, state_n;
    logic [PH_W-1:0]    phase, phase_n, next_ph;
    logic [CNT_W-1:0]   t, t_n;
    logic [TW-1:0]      t_inc;
    logic [N_PHASE-1:0] req_q;
    logic [N_PHASE-1:1] pend, pend_n;
    logic [N_PHASE-1:0] pend_full;
    logic [N_PHASE-1:0] sel;
    logic [N_PHASE-1:0] grn_n, ylw_n, red_n;
    logic               done, found, enter_green;
    int unsigned        idx;

    tlc_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (CK),
        .rst  (CLR),
        .test (io.test),
        .tick (io.tick)
    );

    // Phase 0 is always a candidate unless it already holds green.
    assign pend_full = {pend, ~(state == ST_GREEN && phase == '0)};

    // Next-state, timer, demand latch, round-robin pick and lamp decode.
    always_comb begin
        state_n = state;
        phase_n = phase;
        t_n     = t;
        pend_n  = pend;
        next_ph = '0;
        found   = 1'b0;
        idx     = 0;
        done    = 1'b0;
        grn_n   = '0;
        ylw_n   = '0;
        red_n   = '1;
        t_inc   = TW'(t) + TW'(1);

        // First pending phase after the current one, wrapping back to it last.
        for (int unsigned k = 1; k <= N_PHASE; k++) begin
            idx = (32'(phase) + k) % N_PHASE;
            if (!found && pend_full[PH_W'(idx)]) begin
                next_ph = PH_W'(idx);
                found   = 1'b1;
            end
        end

        case (state)
            ST_ALLRED: done = io.tick && (t_inc >= TW'(ALLRED_TIME));
            ST_GREEN: begin
                if (phase == '0)
                    done = io.tick && (t_inc >= TW'(GREEN_MIN)) && (|pend);
                else
                    done = io.tick && (((t_inc >= TW'(GREEN_MIN)) && !req_q[phase])
                                       || (t_inc >= TW'(GREEN_MAX)));
            end
            ST_YELLOW: done = io.tick && (t_inc >= TW'(YLW_TIME));
            default:   done = 1'b1;
        endcase

        if (done) begin
            t_n = '0;
            case (state)
                ST_ALLRED: begin
                    state_n = ST_GREEN;
                    phase_n = next_ph;
                end
                ST_GREEN:  state_n = ST_YELLOW;
                default:   state_n = ST_ALLRED;
            endcase
        end else if (io.tick && (t != '1)) begin
            t_n = t + CNT_W'(1);
        end

        // Demand is latched while a phase is not green; entry to its green clears it.
        enter_green = done && (state == ST_ALLRED);
        for (int unsigned p = 1; p < N_PHASE; p++) begin
            if (enter_green && (phase_n == PH_W'(p)))
                pend_n[p] = 1'b0;
            else if (req_q[p] && !(state == ST_GREEN && phase == PH_W'(p)))
                pend_n[p] = 1'b1;
        end

        sel = N_PHASE'(1) << phase_n;
        case (lamp_of_state(state_n))
            LAMP_GRN: begin
                grn_n = sel;
                red_n = ~sel;
            end
            LAMP_YLW: begin
                ylw_n = sel;
                red_n = ~sel;
            end
            default: ;
        endcase
    end

    // State, timer, demand and registered lamp outputs.
    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            state    <= ST_ALLRED;
            phase    <= '0;
            t        <= '0;
            pend     <= '0;
            req_q    <= '0;
            io.grn   <= '0;
            io.ylw   <= '0;
            io.red   <= '1;
            io.phase <= '0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            t        <= t_n;
            pend     <= pend_n;
            req_q    <= io.req;
            io.grn   <= grn_n;
            io.ylw   <= ylw_n;
            io.red   <= red_n;
            io.phase <= phase_n;
        end
    end
endmodule

// File: tb/tb_tlc_multi_phase.sv
// Directed bench for tlc_multi_phase with N_PHASE=4 and default timing.
module tb_tlc_multi_phase;

    typedef struct {
        int kind;   // 0 all-red, 1 green, 2 yellow
        int ph;     // owning / last-owner phase
        int len;    // expected cycles; 0 = snapshot only, -1 = length not checked
    } seg_t;

    logic CK = 1'b0;
    logic CLR;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    tlc_multi_phase_if #(.N_PHASE(4)) bus ();

    tlc_multi_phase #(
        .N_PHASE     (4),
        .CNT_W       (8),
        .PRESCALE    (16),
        .GREEN_MIN   (4),
        .GREEN_MAX   (12),
        .YLW_TIME    (2),
        .ALLRED_TIME (1)
    ) dut (
        .CK  (CK),
        .CLR (CLR),
        .io  (bus)
    );

    always #5 CK = ~CK;

    // Expected {grn, ylw, red} for a lamp kind owned by phase ph.
    function automatic logic [11:0] lamp_vec(input int kind, input int ph);
        logic [3:0] s;
        s = 4'b0001 << ph;
        case (kind)
            1:       return {s, 4'b0000, ~s};
            2:       return {4'b0000, s, ~s};
            default: return {8'b0, 4'b1111};
        endcase
    endfunction

    // Record current lamp pattern and count cycles until it changes (bounded).
    task automatic capture(input int limit, output logic [3:0] g, output logic [3:0] y,
                           output logic [3:0] r, output logic [1:0] ph, output int len);
        g = bus.grn; y = bus.ylw; r = bus.red; ph = bus.phase;
        len = 1;
        while (len < limit) begin
            @(negedge CK);
            if ({bus.grn, bus.ylw, bus.red, bus.phase} !== {g, y, r, ph}) break;
            len++;
        end
    endtask

    task automatic test_reset();
        int stable;
        repeat (2) @(negedge CK);
        total_cnt++;
        if ({bus.grn, bus.ylw, bus.red, bus.phase, bus.tick} !== {4'b0, 4'b0, 4'b1111, 2'd0, 1'b0}) begin
            $display("FAIL reset_vals: got g=%b y=%b r=%b ph=%0d tick=%b, expected g=0000 y=0000 r=1111 ph=0 tick=0",
                     bus.grn, bus.ylw, bus.red, bus.phase, bus.tick);
        end else pass_cnt++;
        CLR = 1'b0;
        @(negedge CK);
        total_cnt++;
        if ({bus.red, bus.grn, bus.tick} !== {4'b1111, 4'b0000, 1'b1}) begin
            $display("FAIL reset_allred: got r=%b g=%b tick=%b, expected r=1111 g=0000 tick=1", bus.red, bus.grn, bus.tick);
        end else pass_cnt++;
        @(negedge CK);
        total_cnt++;
        if ({bus.grn, bus.red} !== {4'b0001, 4'b1110}) begin
            $display("FAIL reset_green0: got g=%b r=%b, expected g=0001 r=1110", bus.grn, bus.red);
        end else pass_cnt++;
        stable = 0;
        repeat (100) begin
            @(negedge CK);
            if (bus.grn === 4'b0001 && bus.red === 4'b1110 && bus.ylw === 4'b0000) stable++;
        end
        total_cnt++;
        if (stable != 100) begin
            $display("FAIL idle_hold: got %0d green0 cycles, expected 100", stable);
        end else pass_cnt++;
    endtask

    task automatic test_single_request();
        seg_t segs[$];
        logic [11:0] exp;
        logic [3:0] g, y, r;
        logic [1:0] ph;
        int len;
        segs.push_back('{1, 0, 2});  segs.push_back('{2, 0, 2});  segs.push_back('{0, 0, 1});
        segs.push_back('{1, 2, 4});  segs.push_back('{2, 2, 2});  segs.push_back('{0, 2, 1});
        segs.push_back('{1, 0, 0});
        bus.req[2] = 1'b1;
        @(negedge CK);
        bus.req[2] = 1'b0;
        foreach (segs[i]) begin
            exp = lamp_vec(segs[i].kind, segs[i].ph);
            if (segs[i].len == 0) begin
                g = bus.grn; y = bus.ylw; r = bus.red; ph = bus.phase; len = 0;
            end else capture(300, g, y, r, ph, len);
            total_cnt++;
            if ({g, y, r} !== exp || ph !== 2'(segs[i].ph) || (segs[i].len > 0 && len != segs[i].len)) begin
                $display("FAIL single_req seg%0d: got g=%b y=%b r=%b ph=%0d len=%0d, expected g=%b y=%b r=%b ph=%0d len=%0d",
                         i, g, y, r, ph, len, exp[11:8], exp[7:4], exp[3:0], segs[i].ph, segs[i].len);
            end else pass_cnt++;
        end
    endtask

    task automatic test_simultaneous();
        seg_t segs[$];
        logic [11:0] exp;
        logic [3:0] g, y, r;
        logic [1:0] ph;
        int len;
        segs.push_back('{1, 0, 2});  segs.push_back('{2, 0, 2});  segs.push_back('{0, 0, 1});
        segs.push_back('{1, 1, 4});  segs.push_back('{2, 1, 2});  segs.push_back('{0, 1, 1});
        segs.push_back('{1, 3, 4});  segs.push_back('{2, 3, 2});  segs.push_back('{0, 3, 1});
        segs.push_back('{1, 0, 0});
        repeat (6) @(negedge CK);
        bus.req[1] = 1'b1;
        bus.req[3] = 1'b1;
        @(negedge CK);
        bus.req[1] = 1'b0;
        bus.req[3] = 1'b0;
        foreach (segs[i]) begin
            exp = lamp_vec(segs[i].kind, segs[i].ph);
            if (segs[i].len == 0) begin
                g = bus.grn; y = bus.ylw; r = bus.red; ph = bus.phase; len = 0;
            end else capture(300, g, y, r, ph, len);
            total_cnt++;
            if ({g, y, r} !== exp || ph !== 2'(segs[i].ph) || (segs[i].len > 0 && len != segs[i].len)) begin
                $display("FAIL round_robin seg%0d: got g=%b y=%b r=%b ph=%0d len=%0d, expected g=%b y=%b r=%b ph=%0d len=%0d",
                         i, g, y, r, ph, len, exp[11:8], exp[7:4], exp[3:0], segs[i].ph, segs[i].len);
            end else pass_cnt++;
        end
    endtask

    task automatic test_held_request();
        seg_t segs[$];
        logic [11:0] exp;
        logic [3:0] g, y, r;
        logic [1:0] ph;
        int len;
        segs.push_back('{1, 0, 2});  segs.push_back('{2, 0, 2});  segs.push_back('{0, 0, 1});
        segs.push_back('{1, 2, 12}); segs.push_back('{2, 2, 2});  segs.push_back('{0, 2, 1});
        segs.push_back('{1, 0, 4});  segs.push_back('{2, 0, 2});  segs.push_back('{0, 0, 1});
        segs.push_back('{1, 2, 4});  segs.push_back('{2, 2, 2});  segs.push_back('{0, 2, 1});
        segs.push_back('{1, 0, 0});
        repeat (6) @(negedge CK);
        bus.req[2] = 1'b1;
        @(negedge CK);
        foreach (segs[i]) begin
            if (i == 9) bus.req[2] = 1'b0;  // release at start of second phase-2 green
            exp = lamp_vec(segs[i].kind, segs[i].ph);
            if (segs[i].len == 0) begin
                g = bus.grn; y = bus.ylw; r = bus.red; ph = bus.phase; len = 0;
            end else capture(300, g, y, r, ph, len);
            total_cnt++;
            if ({g, y, r} !== exp || ph !== 2'(segs[i].ph) || (segs[i].len > 0 && len != segs[i].len)) begin
                $display("FAIL held_req seg%0d: got g=%b y=%b r=%b ph=%0d len=%0d, expected g=%b y=%b r=%b ph=%0d len=%0d",
                         i, g, y, r, ph, len, exp[11:8], exp[7:4], exp[3:0], segs[i].ph, segs[i].len);
            end else pass_cnt++;
        end
    endtask

    task automatic test_prescaled();
        seg_t segs[$];
        logic [11:0] exp;
        logic [3:0] g, y, r;
        logic [1:0] ph;
        int len;
        int d;
        segs.push_back('{1, 0, -1}); segs.push_back('{2, 0, 32}); segs.push_back('{0, 0, 16});
        segs.push_back('{1, 1, 64}); segs.push_back('{2, 1, 32}); segs.push_back('{0, 1, 16});
        segs.push_back('{1, 0, 0});
        bus.test = 1'b0;
        d = 0;
        do begin
            @(negedge CK);
            d++;
        end while (bus.tick !== 1'b1 && d < 40);
        total_cnt++;
        if (d != 16) begin
            $display("FAIL tick_restart: got first tick after %0d cycles, expected 16", d);
        end else pass_cnt++;
        d = 0;
        do begin
            @(negedge CK);
            d++;
        end while (bus.tick !== 1'b1 && d < 40);
        total_cnt++;
        if (d != 16) begin
            $display("FAIL tick_period: got %0d cycles, expected 16", d);
        end else pass_cnt++;
        bus.req[1] = 1'b1;
        @(negedge CK);
        bus.req[1] = 1'b0;
        foreach (segs[i]) begin
            exp = lamp_vec(segs[i].kind, segs[i].ph);
            if (segs[i].len == 0) begin
                g = bus.grn; y = bus.ylw; r = bus.red; ph = bus.phase; len = 0;
            end else capture(300, g, y, r, ph, len);
            total_cnt++;
            if ({g, y, r} !== exp || ph !== 2'(segs[i].ph) || (segs[i].len > 0 && len != segs[i].len)) begin
                $display("FAIL prescaled seg%0d: got g=%b y=%b r=%b ph=%0d len=%0d, expected g=%b y=%b r=%b ph=%0d len=%0d",
                         i, g, y, r, ph, len, exp[11:8], exp[7:4], exp[3:0], segs[i].ph, segs[i].len);
            end else pass_cnt++;
        end
        bus.test = 1'b1;
    endtask

    task automatic test_clr_mid();
        int w;
        int stable;
        repeat (10) @(negedge CK);
        bus.req[1] = 1'b1;
        bus.req[3] = 1'b1;
        @(negedge CK);
        bus.req[1] = 1'b0;
        bus.req[3] = 1'b0;
        w = 0;
        while (bus.ylw !== 4'b0010 && w < 60) begin
            @(negedge CK);
            w++;
        end
        total_cnt++;
        if (bus.ylw !== 4'b0010) begin
            $display("FAIL clr_reach_ylw1: got ylw=%b after %0d cycles, expected ylw=0010", bus.ylw, w);
        end else pass_cnt++;
        CLR = 1'b1;
        #1;
        total_cnt++;
        if ({bus.grn, bus.ylw, bus.red, bus.phase, bus.tick} !== {4'b0, 4'b0, 4'b1111, 2'd0, 1'b0}) begin
            $display("FAIL clr_async: got g=%b y=%b r=%b ph=%0d tick=%b, expected g=0000 y=0000 r=1111 ph=0 tick=0",
                     bus.grn, bus.ylw, bus.red, bus.phase, bus.tick);
        end else pass_cnt++;
        @(negedge CK);
        CLR = 1'b0;
        @(negedge CK);
        total_cnt++;
        if ({bus.grn, bus.ylw, bus.red} !== {4'b0, 4'b0, 4'b1111}) begin
            $display("FAIL clr_allred: got g=%b y=%b r=%b, expected g=0000 y=0000 r=1111", bus.grn, bus.ylw, bus.red);
        end else pass_cnt++;
        @(negedge CK);
        total_cnt++;
        if ({bus.grn, bus.red, bus.phase} !== {4'b0001, 4'b1110, 2'd0}) begin
            $display("FAIL clr_green0: got g=%b r=%b ph=%0d, expected g=0001 r=1110 ph=0", bus.grn, bus.red, bus.phase);
        end else pass_cnt++;
        // Phase 3 demand latched before the clear must be gone: main road holds.
        stable = 0;
        repeat (30) begin
            @(negedge CK);
            if (bus.grn === 4'b0001 && bus.ylw === 4'b0000) stable++;
        end
        total_cnt++;
        if (stable != 30) begin
            $display("FAIL clr_pend_cleared: got %0d green0 cycles, expected 30", stable);
        end else pass_cnt++;
    endtask

    initial begin
        CLR      = 1'b1;
        bus.test = 1'b1;
        bus.req  = 4'b0000;
        test_reset();
        test_single_request();
        test_simultaneous();
        test_held_request();
        test_prescaled();
        test_clr_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, expected finish");
        $fatal(1);
    end

endmodule
